// File: rtl/butterfly_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package butterfly_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  // Returns {rs1 is signed, rs2 is signed}; MUL only keeps the low half, so its sign is irrelevant.
  function automatic logic [1:0] is_signed(muldiv_op_e op);
    logic [1:0] s;
    s = 2'b00;
    case (op)
      OP_MULH, OP_DIV, OP_REM: s = 2'b11;
      OP_MULHSU:               s = 2'b10;
      default:                 s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration on the {acc, opr} pair: shift-add multiply (LSB first) or
// restoring shift-subtract divide (MSB first, quotient bits shifted into opr).
module muldiv_iter_step
  import butterfly_pkg::*;
(
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] opr_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] opr_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] partial;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + (opr_i[0] ? {1'b0, operand_b_i} : {(XLEN+1){1'b0}});
    partial = {acc_i, opr_i[XLEN-1]};
    diff    = partial - {1'b0, operand_b_i};
    if (is_div_i) begin
      // A borrow out of the subtraction means the divisor did not fit: restore.
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = partial[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[XLEN:1];
      opr_o = {sum[0], opr_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with EX-stage stall and flush handshake.
// Define BF_FAST_MUL_EN to send MUL* through a single-cycle multiplier on the fast path.
module muldiv_unit
  import butterfly_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e   state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc, opr, mag_b;
  muldiv_op_e      op_q;
  logic            neg_q;

  muldiv_op_e      op_in;
  logic [1:0]      sgn;
  logic            s_a, s_b, neg_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero, div_ovf, fast_path;
  logic [XLEN-1:0] fast_result, iter_result;
  logic [XLEN-1:0] step_acc, step_opr;
  logic [2*XLEN-1:0] prod_full, prod_fix;

  assign op_in    = muldiv_op_e'(op_i);
  assign sgn      = is_signed(op_in);
  assign s_a      = sgn[1] & rs1_i[XLEN-1];
  assign s_b      = sgn[0] & rs2_i[XLEN-1];
  assign mag_a_in = s_a ? -rs1_i : rs1_i;
  assign mag_b_in = s_b ? -rs2_i : rs2_i;
  // Remainder takes the dividend's sign; products and quotients take sA^sB.
  assign neg_in   = (is_div(op_in) & op_in[1]) ? s_a : (s_a ^ s_b);
  assign div_zero = is_div(op_in) & (rs2_i == '0);
  assign div_ovf  = is_div(op_in) & sgn[1] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);

  assign busy_o = rst_ni & (((state == IDLE) & start_i & !flush_i) | (state == CALC));

`ifdef BF_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{s_a}}, rs1_i} * {{XLEN{s_b}}, rs2_i};
  assign fast_path = div_zero | div_ovf | !is_div(op_in);
`else
  assign fast_path = div_zero | div_ovf;
`endif

  always_comb begin
    fast_result = '0;
    if (div_zero) begin
      fast_result = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : rs1_i;
    end else if (div_ovf) begin
      fast_result = (op_in == OP_DIV) ? rs1_i : '0;
    end
`ifdef BF_FAST_MUL_EN
    else if (!is_div(op_in)) begin
      fast_result = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  muldiv_iter_step u_step (
    .is_div_i    (is_div(op_q)),
    .acc_i       (acc),
    .opr_i       (opr),
    .operand_b_i (mag_b),
    .acc_o       (step_acc),
    .opr_o       (step_opr)
  );

  // Sign fix-up is applied to the final step output so the result lands with done_o.
  always_comb begin
    prod_full   = {step_acc, step_opr};
    prod_fix    = neg_q ? -prod_full : prod_full;
    iter_result = '0;
    case (op_q)
      OP_MUL:                       iter_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: iter_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              iter_result = neg_q ? -step_opr : step_opr;
      OP_REM, OP_REMU:              iter_result = neg_q ? -step_acc : step_acc;
      default:                      iter_result = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opr      <= '0;
      mag_b    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      count  <= '0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            if (fast_path) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= fast_result;
            end else begin
              state <= CALC;
              count <= '0;
              acc   <= '0;
              opr   <= mag_a_in;
              mag_b <= mag_b_in;
              op_q  <= op_in;
              neg_q <= neg_in;
            end
          end
        end
        CALC: begin
          acc <= step_acc;
          opr <= step_opr;
          if (count == CW'(XLEN-1)) begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= iter_result;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          count  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and corner RV32M operations against an arithmetic model.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [31:0] last_result = '0;
  exp_t sb[$];

  muldiv_unit dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M semantics expressed with wide integer arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, ua, ub, q;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    case (op)
      3'd0: begin p = ua * ub;    return p[31:0];  end
      3'd1: begin p = sa * sb_;   return p[63:32]; end
      3'd2: begin p = sa * ub;    return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb_; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb_; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] b, input logic [31:0] a);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef BF_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done_o=1 result 0x%08h expected no pulse", result_o);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_result"}, result_o, e.res);
        checkOutput({e.name, "_done_cycle"}, cyc, e.cyc);
        checkOutput({e.name, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
        last_result = e.res;
      end
    end
  end

  // Starts an operation without expecting a result; returns the accept cycle.
  task automatic startRaw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int t);
    @(negedge clk_i);
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    t = cyc;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    int   lat, busy_cnt, n;
    lat = refLatency(op, b, a);
    @(negedge clk_i);
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    e.res = refModel(op, a, b); e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    #1 busy_cnt = busy_o ? 1 : 0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      #1 if (busy_o) busy_cnt++;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no done_o within 100 cycles expected done_o", name);
      sb.delete();
    end else begin
      checkOutput({name, "_busy_cycles"}, busy_cnt, lat);
      repeat (2) @(negedge clk_i);
      checkOutput({name, "_result_held"}, result_o, last_result);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t, d0;
    // Reset state with start_i asserted: busy must still be forced low.
    start_i = 1'b1;
    #12;
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_done", {31'd0, done_o}, 32'd0);
    checkOutput("reset_result", result_o, 32'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    applyStimulus(3'd5, 32'd100, 32'd7, "divu_100_7");
    applyStimulus(3'd7, 32'd100, 32'd7, "remu_100_7");
    applyStimulus(3'd4, -32'sd100, 32'd7, "div_m100_7");
    applyStimulus(3'd6, -32'sd100, 32'd7, "rem_m100_7");
    applyStimulus(3'd4, 32'd5, 32'd0, "div_by_zero");
    applyStimulus(3'd7, 32'd5, 32'd0, "remu_by_zero");
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");

    // Flush in the 10th CALC cycle: no result, unit free for the next instruction.
    startRaw(3'd5, 32'hDEAD_BEEF, 32'd3, t);
    while (cyc < t + 10) @(negedge clk_i);
    flush_i = 1'b1;
    d0 = done_seen;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("flush_busy_next", {31'd0, busy_o}, 32'd0);
    repeat (40) @(negedge clk_i);
    checkOutput("flush_no_done", done_seen - d0, 32'd0);
    checkOutput("flush_result_kept", result_o, last_result);
    applyStimulus(3'd5, 32'd9, 32'd3, "divu_after_flush");

    // Asynchronous reset in the middle of CALC.
    startRaw(3'd5, 32'h1234_5678, 32'd11, t);
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("midreset_done", {31'd0, done_o}, 32'd0);
    checkOutput("midreset_result", result_o, 32'd0);
    last_result = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(3'd0, 32'd6, 32'd7, "mul_after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
